// File: rtl/rename_pkg.sv
// Shared widths, opcode encodings and the destination-write predicate
// used by the rename stage and its free-list allocator.
package rename_pkg;

  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  function automatic logic writes_rd(input logic [6:0] op, input logic [AREG_W-1:0] rd);
    return (op != OP_STORE) && (op != OP_BRANCH) && (rd != '0);
  endfunction

endpackage

// File: rtl/free_list_alloc.sv
// Physical-register free pool: lowest/second-lowest free pickers, free count,
// and per-cycle allocate/release update.
module free_list_alloc
  import rename_pkg::*;
#(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_take_lo,
  input  logic              i_take_hi,
  input  logic              i_free_en_1,
  input  logic [PREG_W-1:0] i_free_preg_1,
  input  logic              i_free_en_2,
  input  logic [PREG_W-1:0] i_free_preg_2,
  output logic [PREG_W-1:0] o_lo_idx,
  output logic [PREG_W-1:0] o_hi_idx,
  output logic [PREG_W:0]   o_free_cnt
);

  logic [NUM_PREGS-1:0] r_free;
  logic [NUM_PREGS-1:0] w_alloc_mask;
  logic [NUM_PREGS-1:0] w_free_mask;
  logic [PREG_W-1:0]    w_lo;
  logic [PREG_W-1:0]    w_hi;
  logic [PREG_W:0]      w_cnt;

  // Scanning downward, each free bit found pushes the previous lowest into w_hi.
  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_cnt = '0;
    for (int unsigned i = 0; i < NUM_PREGS; i++) begin
      if (r_free[NUM_PREGS-1-i]) begin
        w_hi = w_lo;
        w_lo = PREG_W'(NUM_PREGS-1-i);
      end
      w_cnt = w_cnt + (PREG_W+1)'(r_free[i]);
    end
  end

  always_comb begin
    w_alloc_mask = '0;
    w_free_mask  = '0;
    if (i_take_lo) w_alloc_mask[w_lo] = 1'b1;
    if (i_take_hi) w_alloc_mask[w_hi] = 1'b1;
    if (i_free_en_1) w_free_mask[i_free_preg_1] = 1'b1;
    if (i_free_en_2) w_free_mask[i_free_preg_2] = 1'b1;
    w_free_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        r_free[i] <= (i >= NUM_AREGS);
      end
    end else begin
      r_free <= (r_free | w_free_mask) & ~w_alloc_mask;
    end
  end

  assign o_lo_idx   = w_lo;
  assign o_hi_idx   = w_hi;
  assign o_free_cnt = w_cnt;

endmodule

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup with intra-bundle forwarding,
// free-list allocation, registered outputs to dispatch.
module rename_stage
  import rename_pkg::*;
#(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_flag_ri,
  input  logic [6:0]        opcode_ri_1,
  input  logic [2:0]        func3_ri_1,
  input  logic [6:0]        func7_ri_1,
  input  logic [AREG_W-1:0] rs1_ri_1,
  input  logic [AREG_W-1:0] rs2_ri_1,
  input  logic [AREG_W-1:0] rd_ri_1,
  input  logic [31:0]       instr_ri_1,
  input  logic [6:0]        opcode_ri_2,
  input  logic [2:0]        func3_ri_2,
  input  logic [6:0]        func7_ri_2,
  input  logic [AREG_W-1:0] rs1_ri_2,
  input  logic [AREG_W-1:0] rs2_ri_2,
  input  logic [AREG_W-1:0] rd_ri_2,
  input  logic [31:0]       instr_ri_2,
  input  logic              free_en_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_en_2,
  input  logic [PREG_W-1:0] free_preg_2,
  output logic              en_flag_ro,
  output logic [6:0]        opcode_ro_1,
  output logic [2:0]        func3_ro_1,
  output logic [6:0]        func7_ro_1,
  output logic [31:0]       instr_ro_1,
  output logic [PREG_W-1:0] ps1_ro_1,
  output logic [PREG_W-1:0] ps2_ro_1,
  output logic [PREG_W-1:0] pd_ro_1,
  output logic [PREG_W-1:0] old_pd_ro_1,
  output logic [6:0]        opcode_ro_2,
  output logic [2:0]        func3_ro_2,
  output logic [6:0]        func7_ro_2,
  output logic [31:0]       instr_ro_2,
  output logic [PREG_W-1:0] ps1_ro_2,
  output logic [PREG_W-1:0] ps2_ro_2,
  output logic [PREG_W-1:0] pd_ro_2,
  output logic [PREG_W-1:0] old_pd_ro_2,
  output logic              stall
);

  logic [PREG_W-1:0] r_rat [NUM_AREGS];

  logic              w_wr_1, w_wr_2, w_fire;
  logic [1:0]        w_needed;
  logic [PREG_W:0]   w_free_cnt;
  logic [PREG_W-1:0] w_lo, w_hi, w_pd_1, w_pd_2;
  logic [PREG_W-1:0] w_ps1_2, w_ps2_2, w_map_rd2;

  assign w_wr_1   = writes_rd(opcode_ri_1, rd_ri_1);
  assign w_wr_2   = writes_rd(opcode_ri_2, rd_ri_2);
  assign w_needed = {1'b0, w_wr_1} + {1'b0, w_wr_2};
  assign stall    = en_flag_ri && (w_free_cnt < (PREG_W+1)'(w_needed));
  assign w_fire   = en_flag_ri && !stall;

  // Slot 2 takes the lowest free reg itself when slot 1 does not allocate.
  assign w_pd_1 = w_lo;
  assign w_pd_2 = w_wr_1 ? w_hi : w_lo;

  assign w_ps1_2   = (w_wr_1 && rs1_ri_2 == rd_ri_1) ? w_pd_1 : r_rat[rs1_ri_2];
  assign w_ps2_2   = (w_wr_1 && rs2_ri_2 == rd_ri_1) ? w_pd_1 : r_rat[rs2_ri_2];
  assign w_map_rd2 = (w_wr_1 && rd_ri_2  == rd_ri_1) ? w_pd_1 : r_rat[rd_ri_2];

  free_list_alloc #(
    .NUM_AREGS(NUM_AREGS),
    .NUM_PREGS(NUM_PREGS)
  ) u_free_list (
    .clk          (clk),
    .rst          (rst),
    .i_take_lo    (w_fire && (w_wr_1 || w_wr_2)),
    .i_take_hi    (w_fire && w_wr_1 && w_wr_2),
    .i_free_en_1  (free_en_1),
    .i_free_preg_1(free_preg_1),
    .i_free_en_2  (free_en_2),
    .i_free_preg_2(free_preg_2),
    .o_lo_idx     (w_lo),
    .o_hi_idx     (w_hi),
    .o_free_cnt   (w_free_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) begin
        r_rat[i] <= PREG_W'(i);
      end
    end else if (w_fire) begin
      if (w_wr_1) r_rat[rd_ri_1] <= w_pd_1;
      if (w_wr_2) r_rat[rd_ri_2] <= w_pd_2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_flag_ro  <= 1'b0;
      opcode_ro_1 <= '0;
      func3_ro_1  <= '0;
      func7_ro_1  <= '0;
      instr_ro_1  <= '0;
      ps1_ro_1    <= '0;
      ps2_ro_1    <= '0;
      pd_ro_1     <= '0;
      old_pd_ro_1 <= '0;
      opcode_ro_2 <= '0;
      func3_ro_2  <= '0;
      func7_ro_2  <= '0;
      instr_ro_2  <= '0;
      ps1_ro_2    <= '0;
      ps2_ro_2    <= '0;
      pd_ro_2     <= '0;
      old_pd_ro_2 <= '0;
    end else begin
      en_flag_ro <= w_fire;
      if (w_fire) begin
        opcode_ro_1 <= opcode_ri_1;
        func3_ro_1  <= func3_ri_1;
        func7_ro_1  <= func7_ri_1;
        instr_ro_1  <= instr_ri_1;
        ps1_ro_1    <= r_rat[rs1_ri_1];
        ps2_ro_1    <= r_rat[rs2_ri_1];
        pd_ro_1     <= w_wr_1 ? w_pd_1 : r_rat[rd_ri_1];
        old_pd_ro_1 <= r_rat[rd_ri_1];
        opcode_ro_2 <= opcode_ri_2;
        func3_ro_2  <= func3_ri_2;
        func7_ro_2  <= func7_ri_2;
        instr_ro_2  <= instr_ri_2;
        ps1_ro_2    <= w_ps1_2;
        ps2_ro_2    <= w_ps2_2;
        pd_ro_2     <= w_wr_2 ? w_pd_2 : w_map_rd2;
        old_pd_ro_2 <= w_map_rd2;
      end
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: vector table plus hand-written
// exhaustion / free / reset sequences, checked through an expected-result queue.
module tb_rename_stage;
  import rename_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_flag_ri = 1'b0;
  logic [6:0]  opcode_ri_1 = '0, opcode_ri_2 = '0, func7_ri_1 = '0, func7_ri_2 = '0;
  logic [2:0]  func3_ri_1 = '0, func3_ri_2 = '0;
  logic [4:0]  rs1_ri_1 = '0, rs2_ri_1 = '0, rd_ri_1 = '0;
  logic [4:0]  rs1_ri_2 = '0, rs2_ri_2 = '0, rd_ri_2 = '0;
  logic [31:0] instr_ri_1 = '0, instr_ri_2 = '0;
  logic        free_en_1 = 1'b0, free_en_2 = 1'b0;
  logic [5:0]  free_preg_1 = '0, free_preg_2 = '0;

  logic        en_flag_ro, stall;
  logic [6:0]  opcode_ro_1, opcode_ro_2, func7_ro_1, func7_ro_2;
  logic [2:0]  func3_ro_1, func3_ro_2;
  logic [31:0] instr_ro_1, instr_ro_2;
  logic [5:0]  ps1_ro_1, ps2_ro_1, pd_ro_1, old_pd_ro_1;
  logic [5:0]  ps1_ro_2, ps2_ro_2, pd_ro_2, old_pd_ro_2;

  rename_stage #(.NUM_AREGS(32), .NUM_PREGS(64)) dut (
    .clk(clk), .rst(rst), .en_flag_ri(en_flag_ri),
    .opcode_ri_1(opcode_ri_1), .func3_ri_1(func3_ri_1), .func7_ri_1(func7_ri_1),
    .rs1_ri_1(rs1_ri_1), .rs2_ri_1(rs2_ri_1), .rd_ri_1(rd_ri_1), .instr_ri_1(instr_ri_1),
    .opcode_ri_2(opcode_ri_2), .func3_ri_2(func3_ri_2), .func7_ri_2(func7_ri_2),
    .rs1_ri_2(rs1_ri_2), .rs2_ri_2(rs2_ri_2), .rd_ri_2(rd_ri_2), .instr_ri_2(instr_ri_2),
    .free_en_1(free_en_1), .free_preg_1(free_preg_1),
    .free_en_2(free_en_2), .free_preg_2(free_preg_2),
    .en_flag_ro(en_flag_ro),
    .opcode_ro_1(opcode_ro_1), .func3_ro_1(func3_ro_1), .func7_ro_1(func7_ro_1),
    .instr_ro_1(instr_ro_1), .ps1_ro_1(ps1_ro_1), .ps2_ro_1(ps2_ro_1),
    .pd_ro_1(pd_ro_1), .old_pd_ro_1(old_pd_ro_1),
    .opcode_ro_2(opcode_ro_2), .func3_ro_2(func3_ro_2), .func7_ro_2(func7_ro_2),
    .instr_ro_2(instr_ro_2), .ps1_ro_2(ps1_ro_2), .ps2_ro_2(ps2_ro_2),
    .pd_ro_2(pd_ro_2), .old_pd_ro_2(old_pd_ro_2),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op1; logic [4:0] rd1, a1, b1;
    logic [6:0] op2; logic [4:0] rd2, a2, b2;
    logic [5:0] ps1_1, ps2_1, pd_1, old_1, ps1_2, ps2_2, pd_2, old_2;
  } vec_t;

  typedef struct packed {
    logic [6:0]  op1, op2, f7_1, f7_2;
    logic [2:0]  f3_1, f3_2;
    logic [31:0] in1, in2;
    logic [5:0]  ps1_1, ps2_1, pd_1, old_1, ps1_2, ps2_2, pd_2, old_2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp = '0;
  vec_t        tbl[7];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned seq_n = 0;

  function automatic vec_t mk(
      input logic [6:0] op1, input logic [4:0] rd1, a1, b1,
      input logic [6:0] op2, input logic [4:0] rd2, a2, b2,
      input logic [5:0] p11, p21, d1, o1, p12, p22, d2, o2);
    vec_t v;
    v.op1 = op1; v.rd1 = rd1; v.a1 = a1; v.b1 = b1;
    v.op2 = op2; v.rd2 = rd2; v.a2 = a2; v.b2 = b2;
    v.ps1_1 = p11; v.ps2_1 = p21; v.pd_1 = d1; v.old_1 = o1;
    v.ps1_2 = p12; v.ps2_2 = p22; v.pd_2 = d2; v.old_2 = o2;
    return v;
  endfunction

  // Two-writer bundle k of the exhaustion run: add x1,x0,x0 / add x2,x1,x2.
  function automatic vec_t vk(input int unsigned k);
    logic [5:0] d1, o1, o2;
    d1 = 6'(32 + 2*k);
    o1 = (k == 0) ? 6'd1 : 6'(30 + 2*k);
    o2 = (k == 0) ? 6'd2 : 6'(31 + 2*k);
    return mk(OP_R, 5'd1, 5'd0, 5'd0, OP_R, 5'd2, 5'd1, 5'd2,
              6'd0, 6'd0, d1, o1, d1, o2, d1 + 6'd1, o2);
  endfunction

  // One-writer bundle: add x1,x0,x0 / sw x2,0(x1); RAT[x2] is p63 after exhaustion.
  function automatic vec_t w1(input logic [5:0] pd, input logic [5:0] old);
    return mk(OP_R, 5'd1, 5'd0, 5'd0, OP_STORE, 5'd0, 5'd1, 5'd2,
              6'd0, 6'd0, pd, old, pd, 6'd63, 6'd0, 6'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, " opcode_ro_1"}, opcode_ro_1, e.op1);
    chk({tag, " func3_ro_1"},  func3_ro_1,  e.f3_1);
    chk({tag, " func7_ro_1"},  func7_ro_1,  e.f7_1);
    chk({tag, " instr_ro_1"},  instr_ro_1,  e.in1);
    chk({tag, " ps1_ro_1"},    ps1_ro_1,    e.ps1_1);
    chk({tag, " ps2_ro_1"},    ps2_ro_1,    e.ps2_1);
    chk({tag, " pd_ro_1"},     pd_ro_1,     e.pd_1);
    chk({tag, " old_pd_ro_1"}, old_pd_ro_1, e.old_1);
    chk({tag, " opcode_ro_2"}, opcode_ro_2, e.op2);
    chk({tag, " func3_ro_2"},  func3_ro_2,  e.f3_2);
    chk({tag, " func7_ro_2"},  func7_ro_2,  e.f7_2);
    chk({tag, " instr_ro_2"},  instr_ro_2,  e.in2);
    chk({tag, " ps1_ro_2"},    ps1_ro_2,    e.ps1_2);
    chk({tag, " ps2_ro_2"},    ps2_ro_2,    e.ps2_2);
    chk({tag, " pd_ro_2"},     pd_ro_2,     e.pd_2);
    chk({tag, " old_pd_ro_2"}, old_pd_ro_2, e.old_2);
  endtask

  task automatic drive(input vec_t v, input logic en);
    seq_n++;
    en_flag_ri  = en;
    opcode_ri_1 = v.op1; rd_ri_1 = v.rd1; rs1_ri_1 = v.a1; rs2_ri_1 = v.b1;
    opcode_ri_2 = v.op2; rd_ri_2 = v.rd2; rs1_ri_2 = v.a2; rs2_ri_2 = v.b2;
    func3_ri_1  = 3'(seq_n);     func7_ri_1 = 7'(seq_n * 3);
    func3_ri_2  = 3'(seq_n + 5); func7_ri_2 = 7'(seq_n * 5 + 1);
    instr_ri_1  = {func7_ri_1, v.b1, v.a1, func3_ri_1, v.rd1, v.op1};
    instr_ri_2  = {func7_ri_2, v.b2, v.a2, func3_ri_2, v.rd2, v.op2};
  endtask

  task automatic apply(input string tag, input vec_t v, input logic en,
                       input logic exp_stall, input logic exp_fire);
    exp_t e;
    @(negedge clk);
    drive(v, en);
    #1;
    chk({tag, " stall"}, stall, exp_stall);
    if (exp_fire) begin
      e.op1 = v.op1; e.op2 = v.op2;
      e.f3_1 = func3_ri_1; e.f7_1 = func7_ri_1; e.in1 = instr_ri_1;
      e.f3_2 = func3_ri_2; e.f7_2 = func7_ri_2; e.in2 = instr_ri_2;
      e.ps1_1 = v.ps1_1; e.ps2_1 = v.ps2_1; e.pd_1 = v.pd_1; e.old_1 = v.old_1;
      e.ps1_2 = v.ps1_2; e.ps2_2 = v.ps2_2; e.pd_2 = v.pd_2; e.old_2 = v.old_2;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " en_flag_ro"}, en_flag_ro, exp_fire);
    if (exp_fire) begin
      if (sb_q.size() == 0) begin
        chk({tag, " scoreboard empty"}, 1, 0);
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        cmp_out(tag, e);
      end
    end else begin
      cmp_out({tag, " hold"}, last_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(OP_R,     5'd3,  5'd1,  5'd2, OP_R,     5'd4,  5'd5,  5'd6,  1,  2, 32,  3,  5,  6, 33,  4);
    tbl[1] = mk(OP_R,     5'd3,  5'd1,  5'd2, OP_R,     5'd7,  5'd3,  5'd3,  1,  2, 34, 32, 34, 34, 35,  7);
    tbl[2] = mk(OP_R,     5'd5,  5'd1,  5'd2, OP_R,     5'd5,  5'd3,  5'd4,  1,  2, 36,  5, 34, 33, 37, 36);
    tbl[3] = mk(OP_R,     5'd8,  5'd5,  5'd5, OP_STORE, 5'd9,  5'd8,  5'd5, 37, 37, 38,  8, 38, 37,  9,  9);
    tbl[4] = mk(OP_STORE, 5'd10, 5'd1,  5'd2, OP_R,     5'd0,  5'd3,  5'd7,  1,  2, 10, 10, 34, 35,  0,  0);
    tbl[5] = mk(OP_BRANCH,5'd11, 5'd0,  5'd5, OP_I,     5'd12, 5'd0,  5'd0,  0, 37, 11, 11,  0,  0, 39, 12);
    tbl[6] = mk(OP_LOAD,  5'd13, 5'd12, 5'd8, OP_R,     5'd13, 5'd13, 5'd3, 39, 38, 40, 13, 40, 34, 41, 40);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset en_flag_ro", en_flag_ro, 0);
    chk("reset stall", stall, 0);
    cmp_out("reset", '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply($sformatf("vec%0d", i), tbl[i], 1'b1, 1'b0, 1'b1);
    end
    apply("idle", tbl[0], 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle clears outputs at once
    @(negedge clk);
    drive(tbl[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst en_flag_ro", en_flag_ro, 0);
    cmp_out("midrst", '0);
    @(negedge clk);
    rst = 1'b0;
    en_flag_ri = 1'b0;
    sb_q.delete();
    last_exp = '0;

    // Exhaust p32..p63 with two-writer bundles
    for (int unsigned k = 0; k < 16; k++) begin
      apply($sformatf("exh%0d", k), vk(k), 1'b1, 1'b0, 1'b1);
    end
    apply("exh16", vk(16), 1'b1, 1'b1, 1'b0);

    free_en_1 = 1'b1; free_preg_1 = 6'd3;
    apply("free3", w1(6'd3, 6'd62), 1'b1, 1'b1, 1'b0);
    free_en_1 = 1'b0;
    apply("alloc3", w1(6'd3, 6'd62), 1'b1, 1'b0, 1'b1);

    free_en_2 = 1'b1; free_preg_2 = 6'd0;
    apply("free0", w1(6'd0, 6'd3), 1'b1, 1'b1, 1'b0);
    free_en_2 = 1'b0;
    apply("after_free0", w1(6'd0, 6'd3), 1'b1, 1'b1, 1'b0);

    free_en_1 = 1'b1; free_preg_1 = 6'd5;
    free_en_2 = 1'b1; free_preg_2 = 6'd5;
    apply("dupfree5", w1(6'd5, 6'd3), 1'b1, 1'b1, 1'b0);
    free_en_1 = 1'b0; free_en_2 = 1'b0;
    apply("two_need_one_free", vk(0), 1'b1, 1'b1, 1'b0);
    apply("alloc5", w1(6'd5, 6'd3), 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Two-wide register-rename stage of the out-of-order RISC-V pipeline, between decode and dispatch.
- Each cycle it maps up to two decoded instructions' architectural registers (x0–x31) to physical registers (p0–p63) through a RAT and a free pool.
- Registered results go to dispatch; each slot also carries the previous mapping of its destination so the ROB can free it at commit.

Parameters:
- NUM_AREGS, 32, architectural registers (5-bit index)
- NUM_PREGS, 64, physical registers (6-bit index)

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- en_flag_ri  in  1  input bundle valid
- opcode_ri_N  in  7  opcode, slot N (N = 1, 2)
- func3_ri_N  in  3  func3, slot N
- func7_ri_N  in  7  func7, slot N
- rs1_ri_N, rs2_ri_N, rd_ri_N  in  5 each  architectural regs, slot N
- instr_ri_N  in  32  raw instruction, slot N
- free_en_N  in  1  commit frees a physical reg, port N
- free_preg_N  in  6  physical reg to free, port N
- en_flag_ro  out  1  output bundle valid
- opcode_ro_N, func3_ro_N, func7_ro_N, instr_ro_N  out  7/3/7/32  passthrough, slot N
- ps1_ro_N, ps2_ro_N  out  6 each  renamed sources, slot N
- pd_ro_N  out  6  renamed destination, slot N
- old_pd_ro_N  out  6  previous mapping of rd (for ROB), slot N
- stall  out  1  combinational: insufficient free regs for the current bundle

Behaviour:
- Reset (async, rst=1):
  - RAT[i]=i for i = 0–31.
  - p0–p31 marked busy; p32–p63 marked free.
  - All outputs 0, including en_flag_ro.
- Timing: one-cycle latency; all _ro outputs are registered on posedge clk.
- Slot-N destination write: wr_N = (opcode_ri_N not in {0100011 store, 1100011 branch}) && rd_ri_N != 0.
- needed = wr_1 + wr_2.
- stall = en_flag_ri && (free count < needed).
- Normal cycle (en_flag_ri=1, no stall):
  - Slot 1 allocates the lowest-numbered free preg.
  - Slot 2 allocates the next-lowest free preg.
  - Allocated pregs become busy.
  - ps1/ps2 of slot 1 = RAT[rs1/rs2] before update.
  - ps1/ps2 of slot 2: use slot 1's new pd when the source equals rd_ri_1 and wr_1; otherwise RAT.
  - old_pd_1 = RAT[rd_1].
  - old_pd_2 = slot 1's new pd when rd_2==rd_1 and wr_1; otherwise RAT[rd_2].
  - RAT update order: slot 1, then slot 2 (slot 2 wins when both write the same rd).
  - en_flag_ro <= 1.
- Non-writing slot: pd_ro = old_pd_ro = RAT[rd] (0 when rd=x0); nothing allocated.
- x0 sources always map to RAT[0]; RAT[0] is never written.
- en_flag_ri=0 or stall:
  - en_flag_ro <= 0.
  - RAT and free pool unchanged except for frees.
  - Data outputs hold their previous values.
- Frees: free_en_N marks free_preg_N free at posedge. The freed reg is not allocatable until the following cycle (allocation uses pre-edge state).
- Freeing p0 is ignored. Duplicate frees are idempotent.
- Free count: popcount of free bits, 0–64.
- No partial rename: a stalled bundle renames neither slot.

Decomposition:
- Shared package rename_pkg:
  - widths AREG_W=5, PREG_W=6
  - opcode constants OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011
- One sub-module is natural: free_list_alloc (64-bit free vector, two lowest-free priority encoders, free count, alloc/free update).
- RAT stays in rename_stage.

Test Plan:
- Reset then bundle: add x3,x1,x2 / sub x4,x5,x6, both R-type.
  - Slot 1: ps1=1, ps2=2, pd=32, old_pd=3.
  - Slot 2: ps1=5, ps2=6, pd=33, old_pd=4.
  - en_flag_ro=1 one cycle later.
- Intra-bundle RAW: add x3,x1,x2 / add x7,x3,x3.
  - Slot 2: ps1=ps2=32, pd=33.
- WAW: both slots write x5.
  - pd 32 and 33; old_pd_2=32.
  - The next bundle reading x5 gets ps=33.
- Store in slot 1, rd=x0 in slot 2.
  - No allocation; next writer gets p32; both pd_ro equal RAT[rd].
- Exhaust pool: 16 two-writer bundles consume p32–p63.
  - 17th bundle: stall=1, en_flag_ro=0, RAT unchanged.
  - Assert free_en_1 with free_preg_1=3: the cycle after the free it renames one writer to p3.
- Assert rst mid-stream: outputs return to 0 immediately; the next bundle allocates p32 again.
